// File: rtl/id_ex_reg_escalar.sv
// Decode-to-execute pipeline register: 2-entry skid buffer with writeback bypass on capture
// and writeback snooping of every buffered operand so held bundles never go stale.
module id_ex_reg_escalar #(
  parameter int REGISTERS = 32,
  parameter int WIDTH     = 16,
  parameter int CTRL_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(REGISTERS)-1:0] in_a1,
  input  logic [$clog2(REGISTERS)-1:0] in_a2,
  input  logic [$clog2(REGISTERS)-1:0] in_a3,
  input  logic [WIDTH-1:0]             in_rd1,
  input  logic [WIDTH-1:0]             in_rd2,
  input  logic [WIDTH-1:0]             in_imm,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         wb_we,
  input  logic [$clog2(REGISTERS)-1:0] wb_a3,
  input  logic [WIDTH-1:0]             wb_wd3,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_op1,
  output logic [WIDTH-1:0]             out_op2,
  output logic [WIDTH-1:0]             out_imm,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [$clog2(REGISTERS)-1:0] out_a3
);

  localparam int AW = $clog2(REGISTERS);

  typedef struct packed {
    logic [AW-1:0]     a1;
    logic [AW-1:0]     a2;
    logic [AW-1:0]     a3;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [WIDTH-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Register file reads combinationally before its posedge write lands, so forward it here.
  function automatic logic [WIDTH-1:0] capture_op(
    input logic [AW-1:0] a, input logic [WIDTH-1:0] rd,
    input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd
  );
    if (a == '0)
      return '0;
    if (we && (wa == a))
      return wd;
    return rd;
  endfunction

  function automatic entry_t snoop(
    input entry_t e, input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd
  );
    entry_t r;
    r = e;
    if (we && (wa != '0)) begin
      if (e.a1 == wa) r.op1 = wd;
      if (e.a2 == wa) r.op2 = wd;
    end
    return r;
  endfunction

  entry_t main_q, main_d, skid_q, skid_d;
  entry_t cap, main_snp, skid_snp;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept, emit;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid && in_ready && !flush;
  assign emit      = main_valid_q && out_ready;

  always_comb begin
    cap      = '0;
    cap.a1   = in_a1;
    cap.a2   = in_a2;
    cap.a3   = in_a3;
    cap.op1  = capture_op(in_a1, in_rd1, wb_we, wb_a3, wb_wd3);
    cap.op2  = capture_op(in_a2, in_rd2, wb_we, wb_a3, wb_wd3);
    cap.imm  = in_imm;
    cap.ctrl = in_ctrl;
    main_snp = snoop(main_q, wb_we, wb_a3, wb_wd3);
    skid_snp = snoop(skid_q, wb_we, wb_a3, wb_wd3);
  end

  always_comb begin
    main_d       = main_snp;
    skid_d       = skid_snp;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_d       = cap;
            main_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (emit && accept) begin
            main_d = cap;
          end else if (emit) begin
            main_valid_d = 1'b0;
          end else if (accept) begin
            skid_d       = cap;
            skid_valid_d = 1'b1;
          end
        end
        2'b11: begin
          if (emit) begin
            main_d       = skid_snp;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_op1  = main_q.op1;
  assign out_op2  = main_q.op2;
  assign out_imm  = main_q.imm;
  assign out_ctrl = main_q.ctrl;
  assign out_a3   = main_q.a3;

endmodule

// File: tb/tb_id_ex_reg_escalar.sv
// Bench for id_ex_reg_escalar: table of capture vectors plus hand sequences for
// backpressure, snoop, flush and async reset; a queue scoreboard checks every emit.
module tb_id_ex_reg_escalar;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_a1, in_a2, in_a3, wb_a3, out_a3;
  logic [15:0] in_rd1, in_rd2, in_imm, wb_wd3;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        wb_we, out_valid, out_ready;
  logic [15:0] out_op1, out_op2, out_imm;

  id_ex_reg_escalar #(.REGISTERS(32), .WIDTH(16), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd3(wb_wd3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_a3(out_a3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1, a2, a3;
    logic [15:0] rd1, rd2, imm;
    logic [7:0]  ctrl;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [15:0] e_op1, e_op2;
  } vec_t;

  typedef struct {
    logic [4:0]  a1, a2, a3;
    logic [15:0] op1, op2, imm;
    logic [7:0]  ctrl;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: evaluated at negedge for the coming posedge (pop emit, apply snoop, push accept).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("emit_unexpected", {24'd0, out_ctrl}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("emit_op1", {16'd0, out_op1}, {16'd0, e.op1});
          check("emit_op2", {16'd0, out_op2}, {16'd0, e.op2});
          check("emit_imm", {16'd0, out_imm}, {16'd0, e.imm});
          check("emit_ctrl", {24'd0, out_ctrl}, {24'd0, e.ctrl});
          check("emit_a3", {27'd0, out_a3}, {27'd0, e.a3});
          $display("emit ctrl=%h op1=%h op2=%h a3=%0d", out_ctrl, out_op1, out_op2, out_a3);
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (wb_we && wb_a3 != 5'd0) begin
          foreach (sb[i]) begin
            if (sb[i].a1 == wb_a3) sb[i].op1 = wb_wd3;
            if (sb[i].a2 == wb_a3) sb[i].op2 = wb_wd3;
          end
        end
        if (in_valid && in_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic set_inputs(input vec_t v);
    in_a1 = v.a1; in_a2 = v.a2; in_a3 = v.a3;
    in_rd1 = v.rd1; in_rd2 = v.rd2; in_imm = v.imm; in_ctrl = v.ctrl;
    wb_we = v.we; wb_a3 = v.wa; wb_wd3 = v.wd;
    cur_exp.a1 = v.a1; cur_exp.a2 = v.a2; cur_exp.a3 = v.a3;
    cur_exp.op1 = v.e_op1; cur_exp.op2 = v.e_op2;
    cur_exp.imm = v.imm; cur_exp.ctrl = v.ctrl;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb_we    = 1'b0;
  endtask

  task automatic offer(input vec_t v, input string name);
    set_inputs(v);
    wait_accept(name);
  endtask

  function automatic vec_t mk(input logic [4:0] a1, input logic [15:0] rd1,
                              input logic [4:0] a2, input logic [15:0] rd2,
                              input logic [15:0] imm, input logic [7:0] ctrl,
                              input logic [4:0] a3, input logic we, input logic [4:0] wa,
                              input logic [15:0] wd, input logic [15:0] e1, input logic [15:0] e2);
    vec_t v;
    v.a1 = a1; v.rd1 = rd1; v.a2 = a2; v.rd2 = rd2; v.imm = imm; v.ctrl = ctrl;
    v.a3 = a3; v.we = we; v.wa = wa; v.wd = wd; v.e_op1 = e1; v.e_op2 = e2;
    return v;
  endfunction

  initial begin
    vec_t v;
    vecs[0] = mk(5'd3, 16'h1111, 5'd4, 16'h2222, 16'h0005, 8'hA5, 5'd7, 0, 5'd0, 16'h0000, 16'h1111, 16'h2222);
    vecs[1] = mk(5'd5, 16'h0000, 5'd6, 16'h3333, 16'h0010, 8'h11, 5'd1, 1, 5'd5, 16'hBEEF, 16'hBEEF, 16'h3333);
    vecs[2] = mk(5'd0, 16'h5555, 5'd2, 16'h4444, 16'h0020, 8'h12, 5'd2, 1, 5'd0, 16'hBEEF, 16'h0000, 16'h4444);
    vecs[3] = mk(5'd8, 16'h0101, 5'd8, 16'h0101, 16'h0030, 8'h13, 5'd3, 1, 5'd8, 16'h7777, 16'h7777, 16'h7777);
    vecs[4] = mk(5'd9, 16'hAAAA, 5'd10, 16'hBBBB, 16'h0040, 8'h14, 5'd4, 1, 5'd11, 16'hCCCC, 16'hAAAA, 16'hBBBB);
    vecs[5] = mk(5'd0, 16'hFFFF, 5'd0, 16'hFFFF, 16'h0050, 8'h15, 5'd5, 0, 5'd0, 16'h0000, 16'h0000, 16'h0000);
    vecs[6] = mk(5'd12, 16'h1234, 5'd13, 16'h5678, 16'h0060, 8'h16, 5'd6, 0, 5'd12, 16'h9999, 16'h1234, 16'h5678);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a1 = '0; in_a2 = '0; in_a3 = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0; in_ctrl = '0;
    wb_we = 1'b0; wb_a3 = '0; wb_wd3 = '0;
    cur_exp = '{default: '0};
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_op1", {16'd0, out_op1}, 32'd0);
    check("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    check("rst_out_a3", {27'd0, out_a3}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: capture bypass rules with out_ready=1, one-cycle latency.
    for (int i = 0; i < 7; i++) begin
      offer(vecs[i], "table");
      @(negedge clk);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_ctrl", {24'd0, out_ctrl}, {24'd0, vecs[i].ctrl});
      $display("vec %0d ctrl=%h op1=%h op2=%h", i, out_ctrl, out_op1, out_op2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: two buffered, third held by the source, then drained in order.
    @(posedge clk); #1;
    out_ready = 1'b0;
    offer(mk(5'd1, 16'h0A01, 5'd2, 16'h0B01, 16'h0001, 8'h01, 5'd1, 0, 5'd0, 16'h0, 16'h0A01, 16'h0B01), "bp1");
    offer(mk(5'd1, 16'h0A02, 5'd2, 16'h0B02, 16'h0002, 8'h02, 5'd2, 0, 5'd0, 16'h0, 16'h0A02, 16'h0B02), "bp2");
    set_inputs(mk(5'd1, 16'h0A03, 5'd2, 16'h0B03, 16'h0003, 8'h03, 5'd3, 0, 5'd0, 16'h0, 16'h0A03, 16'h0B03));
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_ctrl", {24'd0, out_ctrl}, 32'h01);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("bp3");
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", sb.size(), 32'd0);

    // Snoop on main and skid entries, then on the skid->main transfer edge.
    out_ready = 1'b0;
    offer(mk(5'd1, 16'h0011, 5'd9, 16'h0001, 16'h0007, 8'h21, 5'd4, 0, 5'd0, 16'h0, 16'h0011, 16'h0001), "sn1");
    offer(mk(5'd3, 16'h0033, 5'd9, 16'h0002, 16'h0008, 8'h22, 5'd5, 0, 5'd0, 16'h0, 16'h0033, 16'h0002), "sn2");
    wb_we = 1'b1; wb_a3 = 5'd9; wb_wd3 = 16'h00FF;
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    check("snoop_main_op2", {16'd0, out_op2}, 32'h00FF);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wb_we = 1'b1; wb_a3 = 5'd3; wb_wd3 = 16'h3333;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
    check("snoop_skid_ctrl", {24'd0, out_ctrl}, 32'h22);
    check("snoop_skid_op2", {16'd0, out_op2}, 32'h00FF);
    check("snoop_move_op1", {16'd0, out_op1}, 32'h3333);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("snoop_drained", sb.size(), 32'd0);

    // Flush in TWO with an offered bundle: nothing may ever be emitted afterwards.
    out_ready = 1'b0;
    offer(mk(5'd1, 16'h0031, 5'd2, 16'h0031, 16'h0, 8'h31, 5'd1, 0, 5'd0, 16'h0, 16'h0031, 16'h0031), "fl1");
    offer(mk(5'd1, 16'h0032, 5'd2, 16'h0032, 16'h0, 8'h32, 5'd1, 0, 5'd0, 16'h0, 16'h0032, 16'h0032), "fl2");
    set_inputs(mk(5'd1, 16'h0033, 5'd2, 16'h0033, 16'h0, 8'h33, 5'd1, 0, 5'd0, 16'h0, 16'h0033, 16'h0033));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Async reset between edges while a bundle is held.
    out_ready = 1'b0;
    offer(mk(5'd1, 16'h0041, 5'd2, 16'h0041, 16'h0, 8'h41, 5'd1, 0, 5'd0, 16'h0, 16'h0041, 16'h0041), "ar1");
    @(negedge clk);
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Normal operation after reset.
    v = vecs[0];
    offer(v, "post_rst");
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
